serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 96 +++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one bit per cycle, LSB first.
// Results load in one shot on the final bit; partial sums stay internal.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] part;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             bit_s;
    logic             bit_c;

    // One-bit full adder on the current LSBs and the registered carry
    assign bit_s = a_sh[0] ^ b_sh[0] ^ carry;
    assign bit_c = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));

    // Control FSM with datapath shift registers and registered outputs.
    // Subtraction is A + ~B + 1, so B is inverted and the carry seeded at capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            cnt   <= '0;
            carry <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            part  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ADD;
                    end
                end
                ADD: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    part  <= {bit_s, part[WIDTH-1:1]};
                    carry <= bit_c;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // carry still holds the carry into the MSB here
                        sum   <= {bit_s, part[WIDTH-1:1]};
                        cout  <= bit_c;
                        ovf   <= carry ^ bit_c;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
